// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath controls as Moore outputs of the current state.
module mc_controller #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit TRAP_EN       = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic       ext,
   output logic       mem_req,
   output logic       illegal,
   output logic [1:0] branch,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StIExec   = 4'd9,
      StIWb     = 4'd10,
      StJump    = 4'd11,
      StTrap    = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] FnAdd   = 6'b100000;
   localparam logic [5:0] FnSub   = 6'b100010;
   localparam logic [5:0] FnAnd   = 6'b100100;
   localparam logic [5:0] FnOr    = 6'b100101;
   localparam logic [5:0] FnSlt   = 6'b101010;

   state_e     state_q, state_d;
   logic [5:0] opc_q, opc_d;
   // Low from reset until the first clock edge after release; keeps all outputs at 0.
   logic       run_q;
   logic       mem_done;
   logic       funct_ok;

   assign mem_done = mem_ready | ~MEM_HANDSHAKE;
   assign funct_ok = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                     (funct == FnOr)  || (funct == FnSlt);
   assign state    = state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StFetch;
         opc_q   <= 6'd0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      pcwrite    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      ext        = 1'b0;
      mem_req    = 1'b0;
      illegal    = 1'b0;
      branch     = 2'b00;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      if (run_q) begin
         case (state_q)
            StFetch: begin
               mem_req    = 1'b1;
               alusrcb    = 2'b01;
               alucontrol = 3'b010;
               if (mem_done) begin
                  irwrite = 1'b1;
                  pcwrite = 1'b1;
                  state_d = StDecode;
               end
            end
            StDecode: begin
               alusrcb    = 2'b11;
               alucontrol = 3'b010;
               // R-type keeps funct, others keep op; the two code sets do not overlap.
               opc_d      = (op == OpRtype) ? funct : op;
               unique case (op)
                  OpLw, OpSw:   state_d = StMemAdr;
                  OpBeq, OpBne: state_d = StBranch;
                  OpAddi, OpOri: state_d = StIExec;
                  OpJ:          state_d = StJump;
                  OpRtype:      state_d = funct_ok ? StExecute : (TRAP_EN ? StTrap : StFetch);
                  default:      state_d = TRAP_EN ? StTrap : StFetch;
               endcase
            end
            StMemAdr: begin
               alusrca    = 1'b1;
               alusrcb    = 2'b10;
               alucontrol = 3'b010;
               ext        = 1'b1;
               state_d    = (opc_q == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
               iord    = 1'b1;
               mem_req = 1'b1;
               if (mem_done) state_d = StMemWb;
            end
            StMemWb: begin
               memtoreg = 1'b1;
               regwrite = 1'b1;
               state_d  = StFetch;
            end
            StMemWr: begin
               iord     = 1'b1;
               mem_req  = 1'b1;
               memwrite = 1'b1;
               if (mem_done) state_d = StFetch;
            end
            StExecute: begin
               alusrca = 1'b1;
               unique case (opc_q)
                  FnAdd:   alucontrol = 3'b010;
                  FnSub:   alucontrol = 3'b110;
                  FnAnd:   alucontrol = 3'b000;
                  FnOr:    alucontrol = 3'b001;
                  FnSlt:   alucontrol = 3'b111;
                  default: alucontrol = 3'b000;
               endcase
               state_d = StAluWb;
            end
            StAluWb: begin
               regdst   = 1'b1;
               regwrite = 1'b1;
               state_d  = StFetch;
            end
            StBranch: begin
               alusrca    = 1'b1;
               alucontrol = 3'b110;
               pcsrc      = 2'b01;
               ext        = 1'b1;
               branch     = {1'b1, opc_q == OpBne};
               state_d    = StFetch;
            end
            StIExec, StIWb: begin
               alucontrol = (opc_q == OpOri) ? 3'b001 : 3'b010;
               ext        = (opc_q != OpOri);
               if (state_q == StIExec) begin
                  alusrca = 1'b1;
                  alusrcb = 2'b10;
                  state_d = StIWb;
               end else begin
                  regwrite = 1'b1;
                  state_d  = StFetch;
               end
            end
            StJump: begin
               pcsrc   = 2'b10;
               pcwrite = 1'b1;
               state_d = StFetch;
            end
            StTrap: begin
               illegal = 1'b1;
            end
            default: state_d = StFetch;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: default instance plus TRAP_EN=0 and MEM_HANDSHAKE=0
// instances sharing the same stimulus.
module tb_mc_controller;

   logic       clk, reset_n, mem_ready;
   logic [5:0] op, funct;

   logic       pcwrite, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
   logic       alusrca, ext, mem_req, illegal;
   logic [1:0] branch, alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   logic       nt_pcwrite, nt_iord, nt_memwrite, nt_irwrite, nt_regdst, nt_memtoreg;
   logic       nt_regwrite, nt_alusrca, nt_ext, nt_mem_req, nt_illegal;
   logic [1:0] nt_branch, nt_alusrcb, nt_pcsrc;
   logic [2:0] nt_alucontrol;
   logic [3:0] nt_state;

   logic       nh_pcwrite, nh_iord, nh_memwrite, nh_irwrite, nh_regdst, nh_memtoreg;
   logic       nh_regwrite, nh_alusrca, nh_ext, nh_mem_req, nh_illegal;
   logic [1:0] nh_branch, nh_alusrcb, nh_pcsrc;
   logic [2:0] nh_alucontrol;
   logic [3:0] nh_state;

   int n_checks = 0;
   int n_fail   = 0;

   mc_controller dut (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .ext(ext), .mem_req(mem_req), .illegal(illegal), .branch(branch),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
   );

   mc_controller #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b0)) dut_nt (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pcwrite(nt_pcwrite), .iord(nt_iord), .memwrite(nt_memwrite), .irwrite(nt_irwrite),
      .regdst(nt_regdst), .memtoreg(nt_memtoreg), .regwrite(nt_regwrite),
      .alusrca(nt_alusrca), .ext(nt_ext), .mem_req(nt_mem_req), .illegal(nt_illegal),
      .branch(nt_branch), .alusrcb(nt_alusrcb), .pcsrc(nt_pcsrc),
      .alucontrol(nt_alucontrol), .state(nt_state)
   );

   mc_controller #(.MEM_HANDSHAKE(1'b0), .TRAP_EN(1'b1)) dut_nh (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
      .pcwrite(nh_pcwrite), .iord(nh_iord), .memwrite(nh_memwrite), .irwrite(nh_irwrite),
      .regdst(nh_regdst), .memtoreg(nh_memtoreg), .regwrite(nh_regwrite),
      .alusrca(nh_alusrca), .ext(nh_ext), .mem_req(nh_mem_req), .illegal(nh_illegal),
      .branch(nh_branch), .alusrcb(nh_alusrcb), .pcsrc(nh_pcsrc),
      .alucontrol(nh_alucontrol), .state(nh_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset pulse between edges, then wait for the enabling edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_pulse_state", state, 4'd0);
      check("rst_pulse_illegal", illegal, 1'b0);
      #2;
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      reset_n   = 1'b0;
      op        = 6'd0;
      funct     = 6'd0;
      mem_ready = 1'b0;
      #12;
      check("reset_state", state, 4'd0);
      check("reset_mem_req", mem_req, 1'b0);
      check("reset_pcwrite", pcwrite, 1'b0);
      reset_n = 1'b1;
      #1;
      check("pre_edge_mem_req", mem_req, 1'b0);
      tick();
      check("fetch_mem_req", mem_req, 1'b1);
      check("fetch_alusrcb", alusrcb, 2'b01);
      check("fetch_aluctl", alucontrol, 3'b010);
      check("fetch_wait_irwrite", irwrite, 1'b0);

      // R-type or
      mem_ready = 1'b1;
      op        = 6'b000000;
      funct     = 6'b100101;
      #1;
      check("r_fetch_irwrite", irwrite, 1'b1);
      check("r_fetch_pcwrite", pcwrite, 1'b1);
      tick();
      check("r_decode_state", state, 4'd1);
      check("r_decode_alusrcb", alusrcb, 2'b11);
      tick();
      funct = 6'b111111;
      check("r_exec_state", state, 4'd6);
      check("r_exec_aluctl", alucontrol, 3'b001);
      check("r_exec_alusrca", alusrca, 1'b1);
      check("r_exec_alusrcb", alusrcb, 2'b00);
      tick();
      check("r_aluwb_state", state, 4'd7);
      check("r_aluwb_regdst", regdst, 1'b1);
      check("r_aluwb_regwrite", regwrite, 1'b1);
      tick();
      check("r_done_state", state, 4'd0);

      // lw with 3 wait cycles in MEMRD
      op = 6'b100011;
      tick();
      check("lw_decode_state", state, 4'd1);
      tick();
      check("lw_memadr_state", state, 4'd2);
      check("lw_memadr_ext", ext, 1'b1);
      check("lw_memadr_alusrcb", alusrcb, 2'b10);
      mem_ready = 1'b0;
      op        = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("lw_memrd_state", state, 4'd3);
         check("lw_memrd_mem_req", mem_req, 1'b1);
         check("lw_memrd_iord", iord, 1'b1);
         if (i == 3) mem_ready = 1'b1;
      end
      tick();
      check("lw_memwb_state", state, 4'd4);
      check("lw_memwb_memtoreg", memtoreg, 1'b1);
      check("lw_memwb_regwrite", regwrite, 1'b1);
      tick();
      check("lw_done_state", state, 4'd0);

      // bne then beq
      op = 6'b000101;
      tick();
      tick();
      check("bne_state", state, 4'd8);
      check("bne_branch", branch, 2'b11);
      check("bne_aluctl", alucontrol, 3'b110);
      check("bne_pcsrc", pcsrc, 2'b01);
      check("bne_ext", ext, 1'b1);
      op = 6'b000100;
      tick();
      check("bne_done_state", state, 4'd0);
      tick();
      tick();
      check("beq_branch", branch, 2'b10);

      // ori
      op = 6'b001101;
      tick();
      tick();
      tick();
      check("ori_iexec_state", state, 4'd9);
      check("ori_iexec_aluctl", alucontrol, 3'b001);
      check("ori_iexec_ext", ext, 1'b0);
      check("ori_iexec_alusrcb", alusrcb, 2'b10);
      tick();
      check("ori_iwb_state", state, 4'd10);
      check("ori_iwb_regwrite", regwrite, 1'b1);
      check("ori_iwb_aluctl", alucontrol, 3'b001);

      // addi
      op = 6'b001000;
      tick();
      tick();
      tick();
      check("addi_iexec_aluctl", alucontrol, 3'b010);
      check("addi_iexec_ext", ext, 1'b1);
      tick();
      check("addi_iwb_ext", ext, 1'b1);

      // j
      op = 6'b000010;
      tick();
      tick();
      tick();
      check("j_state", state, 4'd11);
      check("j_pcsrc", pcsrc, 2'b10);
      check("j_pcwrite", pcwrite, 1'b1);
      tick();
      check("j_done_state", state, 4'd0);

      // sw aborted by reset while waiting in MEMWR
      op = 6'b101011;
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      check("sw_memwr_state", state, 4'd5);
      check("sw_memwr_memwrite", memwrite, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("sw_rst_memwrite", memwrite, 1'b0);
      check("sw_rst_state", state, 4'd0);
      check("sw_rst_mem_req", mem_req, 1'b0);
      #2;
      reset_n = 1'b1;
      tick();
      check("post_rst_mem_req", mem_req, 1'b1);
      mem_ready = 1'b1;
      op        = 6'b000000;
      funct     = 6'b100010;
      tick();
      check("post_rst_decode", state, 4'd1);
      tick();
      check("post_rst_exec_aluctl", alucontrol, 3'b110);
      tick();
      tick();
      check("post_rst_done", state, 4'd0);

      // illegal op: TRAP_EN=1 traps, TRAP_EN=0 refetches
      op = 6'b111111;
      tick();
      tick();
      check("ill_trap_state", state, 4'd12);
      check("ill_nt_state", nt_state, 4'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("ill_trap_hold", state, 4'd12);
         check("ill_trap_illegal", illegal, 1'b1);
         check("ill_trap_pcwrite", pcwrite, 1'b0);
         check("ill_nt_illegal", nt_illegal, 1'b0);
      end
      do_reset();
      check("trap_exit_mem_req", mem_req, 1'b1);

      // R-type with illegal funct
      op    = 6'b000000;
      funct = 6'b000000;
      tick();
      tick();
      check("badfn_trap_state", state, 4'd12);
      check("badfn_nt_state", nt_state, 4'd0);

      // MEM_HANDSHAKE=0 instance proceeds with mem_ready low
      mem_ready = 1'b0;
      op        = 6'b100011;
      do_reset();
      check("nh_fetch_irwrite", nh_irwrite, 1'b1);
      check("hs_fetch_irwrite", irwrite, 1'b0);
      tick();
      check("nh_decode", nh_state, 4'd1);
      check("hs_fetch_hold", state, 4'd0);
      tick();
      check("nh_memadr", nh_state, 4'd2);
      tick();
      check("nh_memrd", nh_state, 4'd3);
      tick();
      check("nh_memwb", nh_state, 4'd4);
      tick();
      check("nh_done", nh_state, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait for mem_ready; 0 = memory states last one cycle and ignore mem_ready.
REQ-002 SHALL have parameter TRAP_EN, default 1, meaning: 1 = illegal op/funct enters TRAP; 0 = illegal op/funct returns to FETCH (NOP).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port op, input, 6 bits: instruction opcode from the instruction register.
REQ-006 SHALL have port funct, input, 6 bits: R-type function field.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-008 SHALL have these outputs, 1 bit each: pcwrite, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, ext, mem_req, illegal.
REQ-009 SHALL have these outputs, 2 bits each: branch (00 none, 10 beq, 11 bne), alusrcb, pcsrc.
REQ-010 SHALL have output alucontrol, 3 bits: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 SHALL have output state, 4 bits: current state, for debug.

Function
REQ-012 SHALL be a Moore FSM with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, TRAP=12; encodings 13-15 SHALL go to FETCH.
REQ-013 SHALL drive every output not listed for the current state to 0.
REQ-014 FETCH SHALL drive: mem_req=1, alusrcb=01, alucontrol=010, pcsrc=00.
REQ-015 FETCH SHALL assert irwrite=1 and pcwrite=1 only in the cycle mem_ready=1 (always, when MEM_HANDSHAKE=0), then go to DECODE; otherwise it SHALL hold.
REQ-016 DECODE SHALL drive alusrcb=11, alucontrol=010.
REQ-017 DECODE SHALL go to: MEMADR (op 100011 lw, 101011 sw), EXECUTE (op 000000 with legal funct), BRANCH (000100 beq, 000101 bne), IEXEC (001000 addi, 001101 ori), JUMP (000010); any other op/funct SHALL go to TRAP or FETCH per TRAP_EN.
REQ-018 Legal funct values SHALL be 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
REQ-019 MEMADR SHALL drive alusrca=1, alusrcb=10, alucontrol=010, ext=1, then go to MEMRD (lw) or MEMWR (sw).
REQ-020 MEMRD SHALL drive iord=1, mem_req=1 and hold until mem_ready, then go to MEMWB.
REQ-021 MEMWB SHALL drive memtoreg=1, regwrite=1 for one cycle, then go to FETCH.
REQ-022 MEMWR SHALL drive iord=1, mem_req=1, memwrite=1 and hold until mem_ready, then go to FETCH.
REQ-023 EXECUTE SHALL drive alusrca=1, alusrcb=00, alucontrol decoded from funct, then go to ALUWB.
REQ-024 ALUWB SHALL drive regdst=1, regwrite=1, then go to FETCH.
REQ-025 BRANCH SHALL drive alusrca=1, alucontrol=110, pcsrc=01, ext=1, branch=10 (beq) or 11 (bne), then go to FETCH; branch taken when zero XOR branch[0], evaluated outside the block.
REQ-026 IEXEC SHALL drive alusrca=1, alusrcb=10; addi: alucontrol=010, ext=1; ori: alucontrol=001, ext=0; then go to IWB.
REQ-027 IWB SHALL drive regwrite=1, regdst=0, memtoreg=0, keep IEXEC's alucontrol/ext, then go to FETCH.
REQ-028 JUMP SHALL drive pcsrc=10, pcwrite=1, then go to FETCH.
REQ-029 TRAP SHALL drive illegal=1 and all write enables 0, and hold until reset.
REQ-030 op/funct SHALL be decoded only in DECODE and latched into a 6-bit internal opcode register; later states SHALL use the latched value.
REQ-031 mem_ready SHALL be ignored outside FETCH, MEMRD, MEMWR; a mem_ready that is held high SHALL complete each access in one cycle.
REQ-032 Latency (MEM_HANDSHAKE=0 or mem_ready always 1) SHALL be: R/addi/ori 4, lw 5, sw 4, beq/bne 3, j 3 cycles.

Reset
REQ-033 reset_n=0 SHALL immediately force state=FETCH, clear the opcode register, and drive all outputs to 0 while asserted (no irwrite/pcwrite/memwrite/regwrite).
REQ-034 reset_n=0 asserted mid-instruction (including inside TRAP or any wait) SHALL abort it; FETCH outputs SHALL resume on the first clock edge after reset_n goes 1.

Verification
REQ-035 Bench: mem_ready=1, op=000000, funct=100101 -> states 0,1,6,7,0; alucontrol=001 in EXECUTE; regdst=1 and regwrite=1 in ALUWB.
REQ-036 Bench: op=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_req=1, iord=1; then MEMWB with memtoreg=1, regwrite=1.
REQ-037 Bench: op=000101 -> BRANCH state with branch=11, alucontrol=110, pcsrc=01; op=001101 -> IEXEC with alucontrol=001, ext=0.
REQ-038 Bench: op=111111 with TRAP_EN=1 -> state=12, illegal=1 held 10+ cycles; with TRAP_EN=0 -> returns to FETCH and illegal stays 0.
REQ-039 Bench: reset_n pulsed low during MEMWR -> memwrite drops to 0 asynchronously, state=0; next fetch proceeds normally.
